// File: rtl/fetch_ctrl.sv
// Fetch controller: run/halt/step FSM driving the PC enable and
// a single-entry instruction buffer toward decode.
module fetch_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATAOUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_req,
  input  logic                     halt_req,
  input  logic                     step_req,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  input  logic [DATAOUT_WIDTH-1:0] imem_rdata,
  output logic                     pc_en,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATAOUT_WIDTH-1:0] instr_out,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic [1:0]               state,
  output logic [31:0]              fetch_count
);

  typedef enum logic [1:0] {
    S_HALT      = 2'b00,
    S_RUN       = 2'b01,
    S_STEP      = 2'b10,
    S_STEP_WAIT = 2'b11
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_valid;
  logic [DATAOUT_WIDTH-1:0]   r_instr;
  logic [ADDRESS_WIDTH-1:0]   r_pc;
  logic [31:0]                r_fetch_count;

  logic w_accept;
  logic w_fetch_state;
  logic w_can_fetch;
  logic w_clear;

  assign w_accept      = r_valid & instr_ready;
  assign w_fetch_state = (r_state == S_RUN) | (r_state == S_STEP);
  assign w_can_fetch   = w_fetch_state & ~redirect
                       & (~r_valid | w_accept);
  // Entry leaves the buffer this edge without being replaced
  assign w_clear       = r_valid & (redirect | instr_ready);

  assign pc_en = ~rst & (w_can_fetch |
                 (redirect & (r_state != S_HALT)));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_HALT: begin
        if (halt_req)      w_state_nxt = S_HALT;
        else if (run_req)  w_state_nxt = S_RUN;
        else if (step_req) w_state_nxt = S_STEP;
      end
      S_RUN: begin
        if (halt_req) w_state_nxt = S_HALT;
      end
      S_STEP: begin
        if (halt_req)         w_state_nxt = S_HALT;
        else if (w_can_fetch) w_state_nxt = S_STEP_WAIT;
      end
      S_STEP_WAIT: begin
        if (halt_req)     w_state_nxt = S_HALT;
        else if (w_clear) w_state_nxt = S_HALT;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HALT;
      r_valid       <= 1'b0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_valid <= 1'b0;
      end else if (w_can_fetch) begin
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_can_fetch) begin
        r_instr       <= imem_rdata;
        r_pc          <= pc_in;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign instr_valid = r_valid;
  assign instr_out   = r_instr;
  assign instr_pc    = r_pc;
  assign state       = r_state;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC/imem model around the DUT, scoreboard
// of fetched words popped when decode accepts them.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] pc;
  logic [31:0] imem_rdata;
  logic        pc_en;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [1:0]  dut_state;
  logic [31:0] fetch_count;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = '0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_cnt = '0;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];

  localparam logic [1:0] HALT = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STEP = 2'b10;
  localparam logic [1:0] SWT  = 2'b11;

  fetch_ctrl #(.ADDRESS_WIDTH(32), .DATAOUT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .redirect   (redirect),
    .pc_in      (pc),
    .imem_rdata (imem_rdata),
    .pc_en      (pc_en),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .state      (dut_state),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = imem(pc);

  // PC block model
  always @(posedge clk or posedge rst) begin
    if (rst)         pc <= '0;
    else if (pc_set) pc <= pc_set_val;
    else if (pc_en)  pc <= redirect ? redir_tgt : pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        ent_t e;
        e = q.pop_front();
        chk("sb_instr_out", instr_out, e.ins);
        chk("sb_instr_pc", instr_pc, e.pc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_cyc();
    #2;
    chk("pc_en_fetch", pc_en, 1);
    q.push_back(ent_t'{pc: pc, ins: imem(pc)});
    exp_cnt = exp_cnt + 32'd1;
    cyc();
    chk("fetch_count", fetch_count, exp_cnt);
    chk("valid_after_fetch", instr_valid, 1);
  endtask

  task automatic idle_cyc();
    #2;
    chk("pc_en_idle", pc_en, 0);
    cyc();
  endtask

  task automatic chk_reset_outs();
    chk("rst_state", dut_state, HALT);
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_pc_en", pc_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset_outs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // continuous fetch A,B,C at 0,4,8
    run_req = 1'b1;
    instr_ready = 1'b1;
    idle_cyc();
    run_req = 1'b0;
    chk("s1_state_run", dut_state, RUN);
    fetch_cyc();
    fetch_cyc();
    fetch_cyc();
    chk("s1_state", dut_state, RUN);
    chk("s1_count3", fetch_count, 3);
    chk("s1_pc8", instr_pc, 32'h8);

    // halt + run together during a fetch
    halt_req = 1'b1;
    run_req = 1'b1;
    fetch_cyc();
    chk("s5_halt", dut_state, HALT);
    halt_req = 1'b0;
    run_req = 1'b0;
    instr_ready = 1'b0;
    idle_cyc();
    chk("s5_hold_valid", instr_valid, 1);
    chk("s5_hold_state", dut_state, HALT);
    instr_ready = 1'b1;
    idle_cyc();
    chk("s5_drained", instr_valid, 0);

    // backpressure at pc 0x10
    run_req = 1'b1;
    instr_ready = 1'b0;
    pc_set = 1'b1;
    pc_set_val = 32'h10;
    idle_cyc();
    run_req = 1'b0;
    pc_set = 1'b0;
    fetch_cyc();
    for (int i = 0; i < 3; i++) begin
      idle_cyc();
      chk("s2_pc_stable", instr_pc, 32'h10);
      chk("s2_out_stable", instr_out, imem(32'h10));
      chk("s2_count", fetch_count, exp_cnt);
    end
    instr_ready = 1'b1;
    fetch_cyc();
    chk("s2_pc14", instr_pc, 32'h14);

    // redirect with valid entry being accepted
    redirect = 1'b1;
    redir_tgt = 32'h100;
    #2 chk("s4_pc_en", pc_en, 1);
    cyc();
    chk("s4_valid0", instr_valid, 0);
    chk("s4_count", fetch_count, exp_cnt);
    chk("s4_stale_pc", instr_pc, 32'h14);
    q.delete();
    redirect = 1'b0;
    fetch_cyc();
    chk("s4_tgt", instr_pc, 32'h100);

    // counter wrap on a fetch
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1 release dut.r_fetch_count;
    exp_cnt = 32'hFFFF_FFFF;
    fetch_cyc();
    chk("s6_wrap", fetch_count, 0);

    // back to HALT, then single step
    halt_req = 1'b1;
    fetch_cyc();
    halt_req = 1'b0;
    idle_cyc();
    chk("s3_pre_halt", dut_state, HALT);
    chk("s3_pre_empty", instr_valid, 0);
    step_req = 1'b1;
    instr_ready = 1'b0;
    idle_cyc();
    step_req = 1'b0;
    chk("s3_step", dut_state, STEP);
    fetch_cyc();
    chk("s3_wait1", dut_state, SWT);
    idle_cyc();
    chk("s3_wait2", dut_state, SWT);
    instr_ready = 1'b1;
    idle_cyc();
    chk("s3_halt", dut_state, HALT);
    chk("s3_empty", instr_valid, 0);
    chk("s3_count", fetch_count, exp_cnt);

    // async reset mid-cycle with full counter
    run_req = 1'b1;
    instr_ready = 1'b0;
    idle_cyc();
    run_req = 1'b0;
    fetch_cyc();
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1 release dut.r_fetch_count;
    run_req = 1'b1;
    #1 rst = 1'b1;
    #1 chk_reset_outs();
    q.delete();
    exp_cnt = '0;
    cyc();
    run_req = 1'b0;
    rst = 1'b0;
    idle_cyc();
    chk("s7_post_state", dut_state, HALT);
    chk("s7_post_count", fetch_count, 0);

    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of PC and instruction-address signals.
REQ-002 Parameter DATAOUT_WIDTH, default 32, width of instruction words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run_req  input  1  request continuous fetch.
REQ-006 halt_req  input  1  request stop of fetch.
REQ-007 step_req  input  1  request fetch of exactly one instruction from HALT.
REQ-008 redirect  input  1  taken branch/jump (PCsrc or jalr) resolved this cycle; flushes buffer.
REQ-009 pc_in  input  ADDRESS_WIDTH  current PC from the PC block, also the instruction-memory address.
REQ-010 imem_rdata  input  DATAOUT_WIDTH  combinational read data of instruction memory at pc_in.
REQ-011 pc_en  output  1  PC advance enable, drives the PC block trigger.
REQ-012 instr_valid  output  1  buffer holds an instruction for decode.
REQ-013 instr_ready  input  1  decode accepts instr_out this cycle.
REQ-014 instr_out  output  DATAOUT_WIDTH  buffered instruction word.
REQ-015 instr_pc  output  ADDRESS_WIDTH  PC of buffered instruction.
REQ-016 state  output  2  FSM state: HALT=00, RUN=01, STEP=10, STEP_WAIT=11.
REQ-017 fetch_count  output  32  number of fetches since reset.

Function
REQ-018 Single-entry buffer {instr_valid, instr_out, instr_pc}; accept = instr_valid & instr_ready.
REQ-019 can_fetch = (state==RUN or state==STEP) & ~redirect & (~instr_valid | accept).
REQ-020 On can_fetch, buffer loads imem_rdata and pc_in at the edge and instr_valid becomes 1.
REQ-021 accept without can_fetch clears instr_valid at the edge; accept with can_fetch keeps it 1 (back-to-back, one instruction per cycle).
REQ-022 pc_en = can_fetch | (redirect & state!=HALT), combinational, same cycle.
REQ-023 redirect clears instr_valid at the edge, overriding accept; instr_out/instr_pc hold stale values.
REQ-024 instr_out/instr_pc change only on a fetch; stable while instr_valid=1 and instr_ready=0.
REQ-025 HALT: halt_req stays HALT; else run_req -> RUN; else step_req -> STEP; no fetch.
REQ-026 RUN: halt_req -> HALT; otherwise stay RUN; run_req/step_req ignored.
REQ-027 STEP: halt_req -> HALT; else can_fetch -> STEP_WAIT; else stay STEP (including redirect cycles).
REQ-028 STEP_WAIT: halt_req -> HALT; else instr_valid cleared this edge (accept or redirect) -> HALT; else stay; no fetch.
REQ-029 Request priority in any cycle: halt_req > run_req > step_req.
REQ-030 Transition to HALT does not flush; a valid entry stays until accepted or redirected.
REQ-031 halt_req in a can_fetch cycle: that fetch completes (pc_en=1, buffer loads), then HALT.
REQ-032 fetch_count increments by 1 per can_fetch cycle, wraps 0xFFFFFFFF -> 0.

Reset
REQ-033 rst=1 immediately forces state=HALT, instr_valid=0, instr_out=0, instr_pc=0, fetch_count=0; pc_en=0 while rst=1.
REQ-034 Reset mid-operation discards the buffered instruction; requests asserted during reset are ignored.
REQ-035 First edge after rst deassertion evaluates REQ-025 normally.

Verification
REQ-036 Reset, run_req 1 cycle, instr_ready=1, pc_in 0,4,8 with imem_rdata A,B,C -> state RUN, pc_en=1 every cycle, instr_out A,B,C with instr_pc 0,4,8 on consecutive cycles, fetch_count=3.
REQ-037 RUN with buffer holding pc 0x10, instr_ready=0 for 3 cycles -> pc_en=0, instr_out/instr_pc stable, fetch_count unchanged; instr_ready=1 -> pc 0x14 loaded next edge.
REQ-038 From HALT, step_req 1 cycle, instr_ready=0 then 1 after 2 cycles -> exactly one fetch, states STEP, STEP_WAIT, STEP_WAIT, HALT; fetch_count +1.
REQ-039 RUN, redirect=1 with instr_valid=1 and instr_ready=1 -> pc_en=1, no buffer load, instr_valid=0 next cycle, fetch_count unchanged.
REQ-040 halt_req and run_req together in RUN during a fetch -> fetch completes, next state HALT, instr_valid stays 1 until accepted.
REQ-041 rst asserted mid-cycle in RUN with instr_valid=1, fetch_count=0xFFFFFFFF -> all outputs per REQ-033 before next edge; separately, one more fetch without reset wraps fetch_count to 0.
